// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter sharing one single-port data memory between two requesters
module data_mem_arbiter #(
   parameter int DEPTH = 64,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdata,
   output logic          m0_ack,
   output logic          m0_err,
   output logic [31:0]   m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdata,
   output logic          m1_ack,
   output logic          m1_err,
   output logic [31:0]   m1_rdata,
   output logic          mem_we,
   output logic          mem_re,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state, next_state;
   logic          last_grant;
   logic          cmd_owner;
   logic          cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata;
   logic          grant_valid;
   logic          grant_sel;
   logic          in_range;
   logic [31:0]   read_value;

   // On a tie the requester that did not win last time is served.
   assign grant_valid = m0_req | m1_req;
   assign grant_sel   = (m0_req && m1_req) ? ~last_grant : m1_req;
   assign in_range    = (cmd_addr < AW'(DEPTH));
   assign read_value  = (in_range && !cmd_we) ? mem_rdata : 32'h0;
   assign mem_addr    = cmd_addr;
   assign mem_wdata   = cmd_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (grant_valid) next_state = ACCESS;
         ACCESS:  next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Strobes are combinational from state so an async reset kills them at once.
   always_comb begin
      mem_we = 1'b0;
      mem_re = 1'b0;
      busy   = (state != IDLE);
      if (state == ACCESS && in_range) begin
         mem_we = cmd_we;
         mem_re = !cmd_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         cmd_owner  <= 1'b0;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         m0_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m0_rdata   <= '0;
         m1_ack     <= 1'b0;
         m1_err     <= 1'b0;
         m1_rdata   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_valid) begin
                  last_grant <= grant_sel;
                  cmd_owner  <= grant_sel;
                  cmd_we     <= grant_sel ? m1_we    : m0_we;
                  cmd_addr   <= grant_sel ? m1_addr  : m0_addr;
                  cmd_wdata  <= grant_sel ? m1_wdata : m0_wdata;
               end
            end
            ACCESS: begin
               if (cmd_owner) begin
                  m1_ack   <= 1'b1;
                  m1_err   <= !in_range;
                  m1_rdata <= read_value;
               end else begin
                  m0_ack   <= 1'b1;
                  m0_err   <= !in_range;
                  m0_rdata <= read_value;
               end
            end
            RESP: begin
               m0_ack <= 1'b0;
               m0_err <= 1'b0;
               m1_ack <= 1'b0;
               m1_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_we, mem_re, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        pre_we;
   logic [5:0]  pre_addr;
   logic [31:0] pre_data;
   logic [31:0] mem [0:63];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.DEPTH(64), .AW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      else if (pre_we) mem[pre_addr] <= pre_data;
   end
   assign mem_rdata = mem[mem_addr[5:0]];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic preload(input logic [5:0] a, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      step();
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(); step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy act=%b exp=0", busy); end
      checks++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin errors++; $display("FAIL rst_ack_err act=%b exp=0000", {m0_ack, m1_ack, m0_err, m1_err}); end
      checks++; if ({mem_we, mem_re} !== 2'b0) begin errors++; $display("FAIL rst_strobe act=%b exp=00", {mem_we, mem_re}); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_bus act=%h/%h exp=0/0", mem_addr, mem_wdata); end
      checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata act=%h/%h exp=0/0", m0_rdata, m1_rdata); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_write_m0();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd5; m0_wdata = 32'hDEADBEEF;
      step();
      checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin errors++; $display("FAIL wr_strobe act=%b%b exp=10", mem_we, mem_re); end
      checks++; if (mem_addr !== 32'd5 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus act=%h/%h exp=5/deadbeef", mem_addr, mem_wdata); end
      checks++; if (busy !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL wr_access act=busy%b ack%b exp=busy1 ack0", busy, m0_ack); end
      step();
      checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL wr_ack act=%b%b%b exp=100", m0_ack, m0_err, m1_ack); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_one_cycle act=%b exp=0", mem_we); end
      m0_req = 1'b0;
      step();
      checks++; if (m0_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_done act=ack%b busy%b exp=ack0 busy0", m0_ack, busy); end
      checks++; if (mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_commit act=%h exp=deadbeef", mem[5]); end
   endtask

   task automatic test_read_m1();
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd5; m1_wdata = 32'h0;
      step();
      checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd5) begin errors++; $display("FAIL rd_strobe act=re%b we%b a%h exp=re1 we0 a5", mem_re, mem_we, mem_addr); end
      step();
      checks++; if (m1_ack !== 1'b1 || m1_rdata !== 32'hDEADBEEF || m1_err !== 1'b0) begin errors++; $display("FAIL rd_ack act=%b %h %b exp=1 deadbeef 0", m1_ack, m1_rdata, m1_err); end
      checks++; if (m0_ack !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL rd_other act=m0ack%b re%b exp=0 0", m0_ack, mem_re); end
      m1_req = 1'b0;
      step();
   endtask

   task automatic test_fairness();
      int n_ack;
      logic expect_m1;
      preload(6'd1, 32'h11111111);
      preload(6'd2, 32'h22222222);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd2;
      n_ack = 0;
      for (int i = 1; i <= 11; i++) begin
         step();
         if (i % 3 == 2) begin
            expect_m1 = (n_ack % 2 == 1);
            checks++;
            if (expect_m1 ? (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_rdata !== 32'h22222222)
                          : (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== 32'h11111111)) begin
               errors++;
               $display("FAIL rr_grant%0d act=m0ack%b m1ack%b m0rd%h m1rd%h exp_owner=m%0d", n_ack, m0_ack, m1_ack, m0_rdata, m1_rdata, expect_m1);
            end
            n_ack++;
         end else begin
            checks++;
            if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL rr_spacing cyc%0d act=%b%b exp=00", i, m0_ack, m1_ack); end
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      step();
   endtask

   task automatic test_out_of_range();
      int strobes;
      preload(6'd63, 32'h63636363);
      strobes = 0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd64; m0_wdata = 32'h1234;
      for (int i = 1; i <= 3; i++) begin
         step();
         if (mem_we || mem_re) strobes++;
         if (i == 2) begin
            checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0) begin errors++; $display("FAIL oor64 act=%b%b %h exp=11 0", m0_ack, m0_err, m0_rdata); end
            m0_req = 1'b0;
         end
      end
      strobes = strobes;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8000_0000;
      for (int i = 1; i <= 3; i++) begin
         step();
         if (mem_we || mem_re) strobes++;
         if (i == 2) begin
            checks++; if (m1_ack !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'h0) begin errors++; $display("FAIL oor_high act=%b%b %h exp=11 0", m1_ack, m1_err, m1_rdata); end
            m1_req = 1'b0;
         end
      end
      checks++; if (strobes != 0) begin errors++; $display("FAIL oor_strobe act=%0d exp=0", strobes); end
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd63;
      step(); step();
      checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'h63636363) begin errors++; $display("FAIL rd63 act=%b%b %h exp=10 63636363", m0_ack, m0_err, m0_rdata); end
      m0_req = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      preload(6'd10, 32'h0BADF00D);
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd10; m0_wdata = 32'hAAAA5555;
      step();
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rm_access act=%b exp=1", mem_we); end
      rst_n = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL rm_drop act=we%b busy%b ack%b exp=000", mem_we, busy, m0_ack); end
      m0_req = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      checks++; if (m0_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_idle act=ack%b busy%b exp=00", m0_ack, busy); end
      // tie straight after reset: M0 must win
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd10;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd63;
      step(); step();
      checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rm_old_value act=%b%b %h exp=10 0badf00d", m0_ack, m1_ack, m0_rdata); end
      m0_req = 1'b0;
      step(); step(); step();
      checks++; if (m1_ack !== 1'b1 || m1_rdata !== 32'h63636363) begin errors++; $display("FAIL rm_m1_next act=%b %h exp=1 63636363", m1_ack, m1_rdata); end
      m1_req = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      int we_pulses;
      int acks;
      we_pulses = 0; acks = 0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd3; m0_wdata = 32'h33;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (mem_we) we_pulses++;
         if (m0_ack) acks++;
         if (i == 4) m0_req = 1'b0;
      end
      checks++; if (we_pulses != 2) begin errors++; $display("FAIL b2b_we act=%0d exp=2", we_pulses); end
      checks++; if (acks != 2) begin errors++; $display("FAIL b2b_ack act=%0d exp=2", acks); end
      checks++; if (busy !== 1'b0 || mem[3] !== 32'h33) begin errors++; $display("FAIL b2b_end act=busy%b mem%h exp=0 33", busy, mem[3]); end
   endtask

   initial begin
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      pre_we = 0; pre_addr = 0; pre_data = 0;
      test_reset();
      test_write_m0();
      test_read_m1();
      test_fairness();
      test_out_of_range();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port 64-word data memory between two requesters: M0 (CPU load/store unit) and M1 (debug/DMA loader).
- Arbitrates round-robin, sequences each access through a fixed 3-state FSM, and drives the memory's write-enable, read-enable, address and write-data.
- Registers read data and returns a one-cycle ack per transaction; out-of-range word addresses are rejected without touching memory.

Parameters:
- DEPTH, 64, number of 32-bit words in the attached memory; valid word addresses are 0..DEPTH-1.
- AW, 32, requester and memory address width (word index, not byte address).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  M0 request; hold high with command stable until m0_ack.
- m0_we  in  1  M0 command: 1 = write, 0 = read.
- m0_addr  in  AW  M0 word address.
- m0_wdata  in  32  M0 write data.
- m0_ack  out  1  one-cycle completion pulse to M0.
- m0_err  out  1  valid with m0_ack: 1 = address out of range.
- m0_rdata  out  32  read result, valid with m0_ack.
- m1_req / m1_we / m1_addr / m1_wdata / m1_ack / m1_err / m1_rdata  same as M0, for M1.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory combinational read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, last_grant=1, m0_ack=m1_ack=0, m0_err=m1_err=0, m0_rdata=m1_rdata=0, mem_we=mem_re=0, mem_addr=0, mem_wdata=0, busy=0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. No other transitions.
- IDLE:
  - At each rising edge, sample m0_req and m1_req.
  - Only one request high: grant it.
  - Both high: grant the requester not in last_grant, then update last_grant. After reset M0 wins the first tie.
  - On grant, latch owner, we, addr and wdata into command registers and move to ACCESS.
  - No request: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata are driven from the command registers.
  - If addr < DEPTH: mem_we = cmd_we and mem_re = !cmd_we.
  - If addr >= DEPTH: mem_we = mem_re = 0 and an error is flagged.
  - At the closing edge: the write commits in memory, mem_rdata is captured into the owner's rdata register (reads only), and the owner's ack and err registers are set. Move to RESP.
- RESP (exactly 1 cycle):
  - Owner's ack=1 and err is valid; mem_we = mem_re = 0.
  - Owner's rdata holds the read value. On a write or an error, rdata=0.
  - Non-owner's ack=0.
  - At the closing edge, clear ack and err and return to IDLE.
  - rdata holds its value until the owner's next ack.
- Latency:
  - Request sampled at edge N, then memory access in cycle N..N+1, then ack high in cycle N+1..N+2.
  - Minimum 3 cycles per transaction. Peak throughput is 1 access per 3 cycles.
- Handshake rules:
  - Requester keeps req and its command stable until it sees ack, then drops req or presents a new command in the ack cycle.
  - req still high at the next IDLE sample is a new transaction; a write would then be repeated.
  - Requests arriving in ACCESS or RESP are not lost; they wait for IDLE.
- Fairness: both requesters continuously requesting alternate M0, M1, M0, ... Neither waits more than one other transaction.
- Address boundaries:
  - addr = DEPTH-1 is valid.
  - addr = DEPTH and all upper-bit patterns (e.g. 0x8000_0000) produce err=1, no memory strobe, rdata=0.
- Reset mid-operation:
  - rst_n low during ACCESS drops mem_we immediately, so the write is not committed.
  - Any pending ack is cleared. The FSM restarts in IDLE with last_grant=1.
- Memory contents are owned by the memory block; the arbiter never resets them.

Test Plan:
- Reset then M0 write addr 5 data 0xDEADBEEF -> mem_we high exactly one cycle with mem_addr=5; m0_ack one pulse 2 cycles after request sample; m0_err=0.
- M1 read addr 5 after the write -> mem_re one cycle; m1_ack with m1_rdata=0xDEADBEEF; m0_ack stays 0.
- Both req held continuously, M0 reads addr 1 and M1 reads addr 2 -> grants alternate M0, M1, M0, M1 (first tie to M0); one ack every 3 cycles.
- M0 write addr 64 data 0x1234 -> mem_we never asserted; m0_ack=1 with m0_err=1, m0_rdata=0; address 63 still reads its previous value.
- rst_n pulsed low during the ACCESS cycle of M0 write addr 10 data 0xAAAA5555 -> mem_we drops immediately; no ack; a subsequent read of addr 10 returns the old value; busy=0.
- Requester holds req one cycle past ack with a write to addr 3 -> a second write transaction occurs; bench checks two mem_we pulses, confirming the handshake rule.
